// File: rtl/dac_spi_frame_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : dac_spi_frame_decoder                                           |
// | Brief  : Oversampling receiver/decoder for 24-bit quad-DAC SPI frames.   |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module dac_spi_frame_decoder #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_sync_n,
    input  logic              spi_din,
    input  logic              ldac_n,
    output logic              frame_valid,
    output logic              frame_err,
    output logic [2:0]        frame_cmd,
    output logic [2:0]        frame_addr,
    output logic [15:0]       frame_data,
    output logic [DATA_W-1:0] dac_a,
    output logic [DATA_W-1:0] dac_b,
    output logic [DATA_W-1:0] dac_c,
    output logic [DATA_W-1:0] dac_d,
    output logic [3:0]        ldac_mask
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHIFT  = 2'd1;
    localparam logic [1:0] c_DECODE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    // Bit order in the synchronizer vector: {ldac_n, din, sync_n, sclk}
    logic [3:0]        r_sync [SYNC_STAGES];
    logic [3:0]        r_prev;
    logic [3:0]        w_cur;
    logic              w_sclk_fall;
    logic              w_sync_fall;
    logic              w_sync_n;
    logic              w_din;
    logic              w_ldac_fall;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nx;
    logic              w_shift;
    logic              w_err;
    logic              w_dec;
    // Only frame bits [21:0] are kept; bits [23:22] shift out unused.
    logic [21:0]       r_sr;
    logic [4:0]        r_bitcnt;

    logic [2:0]        w_cmd;
    logic [2:0]        w_addr;
    logic [15:0]       w_data;
    logic [DATA_W-1:0] w_val;
    logic [3:0]        w_sel;

    logic [DATA_W-1:0] r_in  [4];
    logic [DATA_W-1:0] r_dac [4];
    logic [3:0]        r_mask;
    logic [DATA_W-1:0] w_in_nx  [4];
    logic [DATA_W-1:0] w_dac_nx [4];
    logic [3:0]        w_mask_nx;

    // Reset to 0 so a sync_n already low after reset is not seen as a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= 4'b0;
            r_prev <= 4'b0;
        end else begin
            r_sync[0] <= {ldac_n, spi_din, spi_sync_n, spi_sclk};
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_cur       = r_sync[SYNC_STAGES-1];
    assign w_sclk_fall = r_prev[0] & ~w_cur[0];
    assign w_sync_n    = w_cur[1];
    assign w_sync_fall = r_prev[1] & ~w_cur[1];
    assign w_din       = w_cur[2];
    assign w_ldac_fall = r_prev[3] & ~w_cur[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_shift    = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            c_IDLE:   if (w_sync_fall) w_state_nx = c_SHIFT;
            c_SHIFT: begin
                if (w_sclk_fall) begin
                    w_shift = 1'b1;
                    if (r_bitcnt == 5'd23) w_state_nx = c_DECODE;
                end else if (w_sync_n) begin
                    w_state_nx = c_IDLE;
                    w_err      = (r_bitcnt != 5'd0);
                end
            end
            c_DECODE: w_state_nx = c_DONE;
            default:  if (w_sync_n) w_state_nx = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr     <= 22'b0;
            r_bitcnt <= 5'd0;
        end else if (r_state == c_IDLE) begin
            r_bitcnt <= 5'd0;
        end else if (w_shift) begin
            r_sr     <= {r_sr[20:0], w_din};
            r_bitcnt <= r_bitcnt + 5'd1;
        end
    end

    assign w_dec  = (r_state == c_DECODE);
    assign w_cmd  = r_sr[21:19];
    assign w_addr = r_sr[18:16];
    assign w_data = r_sr[15:0];
    assign w_val  = w_data[15 -: DATA_W];

    always_comb begin
        w_sel = 4'b0;
        if (!w_addr[2])             w_sel[w_addr[1:0]] = 1'b1;
        else if (w_addr == 3'b111)  w_sel = 4'hF;
    end

    // Frame write first, then the LDAC transfer sees post-write input values.
    always_comb begin
        w_in_nx   = r_in;
        w_dac_nx  = r_dac;
        w_mask_nx = r_mask;
        if (w_dec) begin
            case (w_cmd)
                3'b000: for (int i = 0; i < 4; i++) if (w_sel[i]) begin
                    w_in_nx[i] = w_val;
                    if (r_mask[i]) w_dac_nx[i] = w_val;
                end
                3'b001: for (int i = 0; i < 4; i++) if (w_sel[i]) w_dac_nx[i] = r_in[i];
                3'b010: begin
                    for (int i = 0; i < 4; i++) if (w_sel[i]) w_in_nx[i] = w_val;
                    for (int i = 0; i < 4; i++) w_dac_nx[i] = w_in_nx[i];
                end
                3'b011: for (int i = 0; i < 4; i++) if (w_sel[i]) begin
                    w_in_nx[i]  = w_val;
                    w_dac_nx[i] = w_val;
                end
                3'b101: begin
                    for (int i = 0; i < 4; i++) begin
                        w_in_nx[i]  = '0;
                        w_dac_nx[i] = '0;
                    end
                    if (w_data[0]) w_mask_nx = 4'b0;
                end
                3'b110: w_mask_nx = w_data[3:0];
                default: ;
            endcase
        end
        if (w_ldac_fall)
            for (int i = 0; i < 4; i++) if (!w_mask_nx[i]) w_dac_nx[i] = w_in_nx[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_in[i]  <= '0;
                r_dac[i] <= '0;
            end
            r_mask      <= 4'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cmd   <= 3'b0;
            frame_addr  <= 3'b0;
            frame_data  <= 16'b0;
        end else begin
            r_in        <= w_in_nx;
            r_dac       <= w_dac_nx;
            r_mask      <= w_mask_nx;
            frame_valid <= w_dec;
            frame_err   <= w_err;
            if (w_dec) begin
                frame_cmd  <= w_cmd;
                frame_addr <= w_addr;
                frame_data <= w_data;
            end
        end
    end

    assign dac_a     = r_dac[0];
    assign dac_b     = r_dac[1];
    assign dac_c     = r_dac[2];
    assign dac_d     = r_dac[3];
    assign ldac_mask = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_frame_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_dac_spi_frame_decoder                                        |
// | Brief  : Directed, table-driven self-checking bench for the decoder.     |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_dac_spi_frame_decoder;

    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sclk = 1'b0, spi_sync_n = 1'b1, spi_din = 1'b0, ldac_n = 1'b1;
    logic frame_valid, frame_err;
    logic [2:0] frame_cmd, frame_addr;
    logic [15:0] frame_data;
    logic [DATA_W-1:0] dac_a, dac_b, dac_c, dac_d;
    logic [3:0] ldac_mask;

    dac_spi_frame_decoder #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_sync_n(spi_sync_n),
        .spi_din(spi_din), .ldac_n(ldac_n), .frame_valid(frame_valid),
        .frame_err(frame_err), .frame_cmd(frame_cmd), .frame_addr(frame_addr),
        .frame_data(frame_data), .dac_a(dac_a), .dac_b(dac_b), .dac_c(dac_c),
        .dac_d(dac_d), .ldac_mask(ldac_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ldac;
        logic [23:0] frame;
        logic [2:0]  cmd;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] a, b, c, d;
        logic [3:0]  mask;
    } vec_t;

    vec_t vecs [15];
    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    logic [2:0]  s_cmd, s_addr;
    logic [15:0] s_data, s_a, s_b, s_c, s_d;
    logic [3:0]  s_mask;

    // Snapshot everything in the very cycle frame_valid is high.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            valid_cnt++;
            s_cmd = frame_cmd; s_addr = frame_addr; s_data = frame_data;
            s_a = dac_a; s_b = dac_b; s_c = dac_c; s_d = dac_d; s_mask = ldac_mask;
        end
        if (frame_err === 1'b1) err_cnt++;
    end

    function automatic vec_t mk(bit l, logic [23:0] f, logic [2:0] c, logic [2:0] ad,
                                logic [15:0] dt, logic [15:0] a, logic [15:0] b,
                                logic [15:0] cc, logic [15:0] d, logic [3:0] m);
        vec_t v;
        v.is_ldac = l; v.frame = f; v.cmd = c; v.addr = ad; v.data = dt;
        v.a = a; v.b = b; v.c = cc; v.d = d; v.mask = m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic shift_bits(input logic [23:0] f, input int from, input int to);
        for (int i = from; i < to; i++) begin
            spi_din  = (i < 24) ? f[23-i] : 1'b1;
            spi_sclk = 1'b1; #40;
            spi_sclk = 1'b0; #40;
        end
    endtask

    task automatic send(input logic [23:0] f, input int n);
        spi_sync_n = 1'b0; #40;
        shift_bits(f, 0, n);
        spi_sync_n = 1'b1; #80;
    endtask

    task automatic wait_valid(input int prev, input string name);
        int t;
        t = 0;
        while (valid_cnt == prev && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (valid_cnt == prev) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic pulse_ldac();
        ldac_n = 1'b0; #80;
        ldac_n = 1'b1; #80;
        @(negedge clk);
    endtask

    initial begin
        int pv, pe;
        vecs[0]  = mk(0, 24'h280001, 3'd5, 3'd0, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        vecs[1]  = mk(0, 24'h373FF0, 3'd6, 3'd7, 16'h3FF0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        vecs[2]  = mk(0, 24'h00A500, 3'd0, 3'd0, 16'hA500, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0);
        vecs[3]  = mk(1, 24'h0,      3'd0, 3'd0, 16'h0,    16'hA500, 16'h0, 16'h0, 16'h0, 4'h0);
        vecs[4]  = mk(0, 24'h004000, 3'd0, 3'd0, 16'h4000, 16'hA500, 16'h0, 16'h0, 16'h0, 4'h0);
        vecs[5]  = mk(0, 24'h015500, 3'd0, 3'd1, 16'h5500, 16'hA500, 16'h0, 16'h0, 16'h0, 4'h0);
        vecs[6]  = mk(0, 24'h02AA00, 3'd0, 3'd2, 16'hAA00, 16'hA500, 16'h0, 16'h0, 16'h0, 4'h0);
        vecs[7]  = mk(0, 24'h13C300, 3'd2, 3'd3, 16'hC300, 16'h4000, 16'h5500, 16'hAA00, 16'hC300, 4'h0);
        vecs[8]  = mk(0, 24'h370F0F, 3'd6, 3'd7, 16'h0F0F, 16'h4000, 16'h5500, 16'hAA00, 16'hC300, 4'hF);
        vecs[9]  = mk(0, 24'h027700, 3'd0, 3'd2, 16'h7700, 16'h4000, 16'h5500, 16'h7700, 16'hC300, 4'hF);
        vecs[10] = mk(1, 24'h0,      3'd0, 3'd0, 16'h0,    16'h4000, 16'h5500, 16'h7700, 16'hC300, 4'hF);
        vecs[11] = mk(0, 24'h051234, 3'd0, 3'd5, 16'h1234, 16'h4000, 16'h5500, 16'h7700, 16'hC300, 4'hF);
        vecs[12] = mk(0, 24'h1F1111, 3'd3, 3'd7, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 4'hF);
        vecs[13] = mk(0, 24'hE0BEEF, 3'd4, 3'd0, 16'hBEEF, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 4'hF);
        vecs[14] = mk(0, 24'h280000, 3'd5, 3'd0, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 4'hF);

        repeat (4) @(negedge clk);
        chk("rst_valid", {31'd0, frame_valid}, 32'd0);
        chk("rst_err",   {31'd0, frame_err},   32'd0);
        chk("rst_frame", {10'd0, frame_cmd, frame_addr, frame_data}, 32'd0);
        chk("rst_dacs",  {dac_a, dac_b} | {dac_c, dac_d}, 32'd0);
        chk("rst_mask",  {28'd0, ldac_mask}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 15; v++) begin
            if (vecs[v].is_ldac) begin
                pulse_ldac();
                chk($sformatf("v%0d_ldac_a", v), {16'd0, dac_a}, {16'd0, vecs[v].a});
                chk($sformatf("v%0d_ldac_b", v), {16'd0, dac_b}, {16'd0, vecs[v].b});
                chk($sformatf("v%0d_ldac_c", v), {16'd0, dac_c}, {16'd0, vecs[v].c});
                chk($sformatf("v%0d_ldac_d", v), {16'd0, dac_d}, {16'd0, vecs[v].d});
            end else begin
                pv = valid_cnt;
                send(vecs[v].frame, 24);
                wait_valid(pv, $sformatf("v%0d", v));
                chk($sformatf("v%0d_cmd", v),  {29'd0, s_cmd},  {29'd0, vecs[v].cmd});
                chk($sformatf("v%0d_addr", v), {29'd0, s_addr}, {29'd0, vecs[v].addr});
                chk($sformatf("v%0d_data", v), {16'd0, s_data}, {16'd0, vecs[v].data});
                chk($sformatf("v%0d_a", v),    {16'd0, s_a},    {16'd0, vecs[v].a});
                chk($sformatf("v%0d_b", v),    {16'd0, s_b},    {16'd0, vecs[v].b});
                chk($sformatf("v%0d_c", v),    {16'd0, s_c},    {16'd0, vecs[v].c});
                chk($sformatf("v%0d_d", v),    {16'd0, s_d},    {16'd0, vecs[v].d});
                chk($sformatf("v%0d_mask", v), {28'd0, s_mask}, {28'd0, vecs[v].mask});
            end
        end

        // Short frame: error pulse, nothing decoded, then a full frame recovers.
        pv = valid_cnt; pe = err_cnt;
        send(24'h1B1234, 13);
        repeat (20) @(negedge clk);
        chk("short_err_cnt",   err_cnt,   pe + 1);
        chk("short_valid_cnt", valid_cnt, pv);
        chk("short_dac_d",     {16'd0, dac_d}, 32'd0);
        send(24'h1B1234, 24);
        wait_valid(pv, "after_short");
        chk("after_short_d", {16'd0, dac_d}, 32'h1234);
        chk("after_short_err", err_cnt, pe + 1);

        // Idle SYNC_n window with no SCLK: no pulses at all.
        pv = valid_cnt; pe = err_cnt;
        spi_sync_n = 1'b0; #200; spi_sync_n = 1'b1; #200;
        chk("empty_valid", valid_cnt, pv);
        chk("empty_err",   err_cnt,   pe);

        // 30 SCLK edges: first 24 decoded, one frame_valid only.
        pv = valid_cnt;
        send(24'h181111, 30);
        repeat (20) @(negedge clk);
        chk("long_valid_cnt", valid_cnt, pv + 1);
        chk("long_cmd",       {29'd0, frame_cmd}, 32'd3);
        chk("long_a",         {16'd0, dac_a}, 32'h1111);
        chk("long_d",         {16'd0, dac_d}, 32'h1234);

        // Reset at bit 10; remainder of the frame must be dropped.
        pv = valid_cnt; pe = err_cnt;
        spi_sync_n = 1'b0; #40;
        shift_bits(24'h1A5555, 0, 10);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("mid_rst_dacs",  {dac_a, dac_b} | {dac_c, dac_d}, 32'd0);
        chk("mid_rst_frame", {10'd0, frame_cmd, frame_addr, frame_data}, 32'd0);
        chk("mid_rst_mask",  {28'd0, ldac_mask}, 32'd0);
        rst = 1'b0;
        shift_bits(24'h1A5555, 10, 24);
        spi_sync_n = 1'b1; #80;
        repeat (20) @(negedge clk);
        chk("mid_rst_valid", valid_cnt, pv);
        chk("mid_rst_err",   err_cnt,   pe);
        chk("mid_rst_c",     {16'd0, dac_c}, 32'd0);
        send(24'h1A5555, 24);
        wait_valid(pv, "post_rst");
        chk("post_rst_c", {16'd0, dac_c}, 32'h5555);
        chk("post_rst_a", {16'd0, dac_a}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
